// File: rtl/cpu_controller.sv
// cpu_controller: run/halt sequencer, decoder, memory stall and retire counter.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt and raise illegal.
module cpu_controller #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [7:0]       func,
  input  logic             zero,
  output logic [2:0]       ALUOP,
  output logic [1:0]       PCSel,
  output logic [1:0]       ALUSel,
  output logic             dataSel,
  output logic             regWriteEn,
  output logic             memWriteEn,
  output logic             changeWnd,
  output logic             pcWriteEn,
  output logic             busy,
  output logic             halted,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_WND   = 4'b0011;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;
  localparam logic [2:0] A_AND = 3'd2;
  localparam logic [2:0] A_OR  = 3'd3;
  localparam logic [2:0] A_NOT = 3'd4;

  localparam bit         STALL    = (MEM_LAT > 1);
  localparam logic [3:0] CNT_INIT = STALL ? 4'(MEM_LAT - 2) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             mem_op;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic             ill_q, ill_d;
  assign illegal = ill_q;
`endif

  assign retired = retired_q;

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      retired_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ill_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
      if (pcWriteEn)
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and decode; enables are forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ALUOP      = A_ADD;
    PCSel      = 2'd0;
    ALUSel     = 2'd0;
    dataSel    = 1'b0;
    regWriteEn = 1'b0;
    memWriteEn = 1'b0;
    changeWnd  = 1'b0;
    pcWriteEn  = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    mem_op     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ill_d      = ill_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) state_d = EXEC;
      end
      HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d = EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          ill_d   = 1'b0;
`endif
        end
      end
      EXEC: begin
        busy      = 1'b1;
        pcWriteEn = 1'b1;
        case (opcode)
          OP_LOAD: begin
            dataSel    = 1'b1;
            regWriteEn = 1'b1;
            mem_op     = 1'b1;
          end
          OP_STORE: begin
            memWriteEn = 1'b1;
            mem_op     = 1'b1;
          end
          OP_JUMP: PCSel = 2'd2;
          OP_WND:  changeWnd = 1'b1;
          OP_BRZ: begin
            ALUOP = A_SUB;
            PCSel = zero ? 2'd1 : 2'd0;
          end
          OP_HALT: state_d = HALT;
          OP_RTYPE: begin
            priority case (1'b1)
              func[0]: begin ALUSel = 2'd1; regWriteEn = 1'b1; end
              func[1]: begin ALUSel = 2'd1; regWriteEn = 1'b1; end
              func[2]: begin ALUOP = A_ADD; regWriteEn = 1'b1; end
              func[3]: begin ALUOP = A_SUB; regWriteEn = 1'b1; end
              func[4]: begin ALUOP = A_AND; regWriteEn = 1'b1; end
              func[5]: begin ALUOP = A_OR;  regWriteEn = 1'b1; end
              func[6]: begin ALUOP = A_NOT; regWriteEn = 1'b1; end
              default: ;
            endcase
          end
          OP_ADDI: begin ALUSel = 2'd2; ALUOP = A_ADD; regWriteEn = 1'b1; end
          OP_SUBI: begin ALUSel = 2'd2; ALUOP = A_SUB; regWriteEn = 1'b1; end
          OP_ANDI: begin ALUSel = 2'd2; ALUOP = A_AND; regWriteEn = 1'b1; end
          OP_ORI:  begin ALUSel = 2'd2; ALUOP = A_OR;  regWriteEn = 1'b1; end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            pcWriteEn = 1'b0;
            state_d   = HALT;
            ill_d     = 1'b1;
`endif
          end
        endcase
        if (mem_op && STALL) begin
          pcWriteEn  = 1'b0;
          regWriteEn = 1'b0;
          memWriteEn = 1'b0;
          cnt_d      = CNT_INIT;
          state_d    = MEMWAIT;
        end
      end
      MEMWAIT: begin
        busy    = 1'b1;
        dataSel = (opcode == OP_LOAD);
        if (cnt_q == 4'd0) begin
          pcWriteEn  = 1'b1;
          regWriteEn = (opcode == OP_LOAD);
          memWriteEn = (opcode == OP_STORE);
          state_d    = EXEC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      regWriteEn = 1'b0;
      memWriteEn = 1'b0;
      changeWnd  = 1'b0;
      pcWriteEn  = 1'b0;
    end
  end

endmodule
